// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and defaults for the cacheline arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   arb_owner_t : which L1 cache currently owns the memory port
//   DEFAULT_*   : default widths used by the arbiter parameters
package arb_types;

  localparam int DEFAULT_LINE_WIDTH = 256;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/cacheline_arbiter_select.sv
// Combinational grant selection for the cacheline arbiter.
// Ports:
//   i_req      : I-side wants the memory port
//   d_req      : D-side wants the memory port (read or writeback)
//   last_owner : owner of the most recently completed transfer
//   grant      : requester to be granted this cycle (OWN_NONE if idle)
// ROUND_ROBIN=1 hands a conflict to whoever was not served last;
// ROUND_ROBIN=0 always hands a conflict to the D-side.
module arbiter_select
  import arb_types::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = OWN_NONE;
    if (i_req && d_req) begin
      grant = ((ROUND_ROBIN != 0) && (last_owner == OWN_D)) ? OWN_I : OWN_D;
    end else if (i_req) begin
      grant = OWN_I;
    end else if (d_req) begin
      grant = OWN_D;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Arbitrates the single physical-memory cacheline port between the
// I-side cache (reads only) and the D-side cache (reads and writebacks).
// A granted command is latched and held on pmem_* until pmem_resp, then
// the requester sees its line (reads) and a one-cycle resp pulse.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   i_read/i_addr         : I-side line request (level) and address
//   i_rdata/i_resp        : I-side returned line and completion pulse
//   d_read/d_write/d_addr : D-side line request (level) and address
//   d_wdata               : D-side writeback line
//   d_rdata/d_resp        : D-side returned line and completion pulse
//   pmem_read/pmem_write  : memory command (registered)
//   pmem_address/wdata    : memory address and write line (registered)
//   pmem_rdata/pmem_resp  : memory returned line and completion pulse
module cacheline_arbiter
  import arb_types::*;
#(
  parameter int LINE_WIDTH  = DEFAULT_LINE_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t last_owner;
  arb_owner_t grant;

  arbiter_select #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_select (
    .i_req      (i_read),
    .d_req      (d_read || d_write),
    .last_owner (last_owner),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      last_owner   <= OWN_I;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle.
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant == OWN_I) begin
            owner        <= OWN_I;
            state        <= BUSY;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= i_addr;
            pmem_wdata   <= '0;
          end else if (grant == OWN_D) begin
            // A simultaneous read and write is illegal; the write wins.
            owner        <= OWN_D;
            state        <= BUSY;
            pmem_read    <= !d_write;
            pmem_write   <= d_write;
            pmem_address <= d_addr;
            pmem_wdata   <= d_write ? d_wdata : '0;
          end
        end
        BUSY: begin
          // The command registers hold steady; requester inputs are not looked at.
          if (pmem_resp) begin
            state      <= RESP;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (owner == OWN_I) begin
              i_rdata <= pmem_rdata;
              i_resp  <= 1'b1;
            end else begin
              // pmem_write still holds the latched op here: writebacks leave d_rdata alone.
              if (!pmem_write) begin
                d_rdata <= pmem_rdata;
              end
              d_resp <= 1'b1;
            end
          end
        end
        RESP: begin
          last_owner <= owner;
          owner      <= OWN_NONE;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  a_no_read_and_write_req: assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write));

  a_one_resp: assert property (@(posedge clk) disable iff (rst)
    !(i_resp && d_resp));

  a_one_cmd: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read && pmem_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter. A round-robin instance runs a
// table of single transactions; hand sequences cover reset during a
// transfer and D-side priority on a fixed-priority instance.
module tb_cacheline_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;

  // Round-robin instance signals.
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;

  // Fixed-priority instance signals.
  logic          f_i_read, f_d_read, f_d_write;
  logic [AW-1:0] f_i_addr, f_d_addr;
  logic [LW-1:0] f_d_wdata, f_i_rdata, f_d_rdata;
  logic          f_i_resp, f_d_resp;
  logic          f_pmem_read, f_pmem_write, f_pmem_resp;
  logic [AW-1:0] f_pmem_address;
  logic [LW-1:0] f_pmem_wdata, f_pmem_rdata;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] exp_i;
  logic [LW-1:0] exp_d;

  always #5 clk = ~clk;

  cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ROUND_ROBIN(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .i_read(f_i_read), .i_addr(f_i_addr), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
    .d_read(f_d_read), .d_write(f_d_write), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
    .d_rdata(f_d_rdata), .d_resp(f_d_resp),
    .pmem_read(f_pmem_read), .pmem_write(f_pmem_write), .pmem_address(f_pmem_address),
    .pmem_wdata(f_pmem_wdata), .pmem_rdata(f_pmem_rdata), .pmem_resp(f_pmem_resp)
  );

  typedef struct {
    logic          i_read;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [AW-1:0] mid_addr;  // nonzero: d_addr is changed to this mid-transfer
    logic [7:0]    wbyte;     // writeback line is this byte repeated
    logic [7:0]    rbyte;     // memory returns this byte repeated
    int            delay;     // cycles the command is high, including the pmem_resp cycle
    logic          hold;      // keep requests raised through the resp cycle
    logic          exp_d;     // 1: D-side expected to own the transfer
    logic          exp_rd;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requests are driven on the falling edge; the next rising edge is the grant edge.
  task automatic do_txn(input vec_t v);
    int hi;
    i_read  = v.i_read;
    d_read  = v.d_read;
    d_write = v.d_write;
    i_addr  = v.i_addr;
    d_addr  = v.d_addr;
    d_wdata = {32{v.wbyte}};
    hi = 0;
    for (int c = 1; c <= v.delay; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (pmem_read || pmem_write) hi++;
      check("busy_pmem_read", 32'(pmem_read), 32'(v.exp_rd));
      check("busy_pmem_write", 32'(pmem_write), 32'(v.exp_wr));
      check("busy_pmem_address", pmem_address, v.exp_addr);
      check("busy_no_resp", 32'({i_resp, d_resp}), 32'd0);
      if (v.exp_wr) check_line("busy_pmem_wdata", pmem_wdata, {32{v.wbyte}});
      if (c == 1 && v.mid_addr != '0) d_addr = v.mid_addr;
      if (c == v.delay) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {32{v.rbyte}};
      end
    end
    @(posedge clk);
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = {32{8'hC7}};
    if (v.exp_d) begin
      if (v.exp_rd) exp_d = {32{v.rbyte}};
    end else begin
      exp_i = {32{v.rbyte}};
    end
    check("cmd_cycles", 32'(hi), 32'(v.delay));
    check("i_resp", 32'(i_resp), 32'(!v.exp_d));
    check("d_resp", 32'(d_resp), 32'(v.exp_d));
    check("resp_cmd_low", 32'({pmem_read, pmem_write}), 32'd0);
    check_line("i_rdata", i_rdata, exp_i);
    check_line("d_rdata", d_rdata, exp_d);
    if (!v.hold) begin
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("after_resp_quiet", 32'({i_resp, d_resp, pmem_read, pmem_write}), 32'd0);
  endtask

  task automatic reset_mid_busy();
    i_read = 1'b1;
    i_addr = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    check("rst_seq_granted", 32'(pmem_read), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    i_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_i = '0;
    exp_d = '0;
    check("rst_cmd", 32'({pmem_read, pmem_write, i_resp, d_resp}), 32'd0);
    check("rst_address", pmem_address, 32'd0);
    check_line("rst_wdata", pmem_wdata, '0);
    check_line("rst_i_rdata", i_rdata, exp_i);
    check_line("rst_d_rdata", d_rdata, exp_d);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = {32{8'hFF}};
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("stray_resp_ignored", 32'({i_resp, d_resp, pmem_read, pmem_write}), 32'd0);
      check_line("stray_i_rdata", i_rdata, exp_i);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Both requests held continuously: fixed priority must serve D every time.
  task automatic fixed_priority();
    f_i_read = 1'b1;
    f_d_read = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk);
      @(negedge clk);
      check("fixed_grant_addr", f_pmem_address, 32'h0000_0080);
      check("fixed_grant_read", 32'(f_pmem_read), 32'd1);
      f_pmem_resp  = 1'b1;
      f_pmem_rdata = {32{8'h66}};
      @(posedge clk);
      @(negedge clk);
      f_pmem_resp = 1'b0;
      check("fixed_d_resp", 32'(f_d_resp), 32'd1);
      check("fixed_i_resp", 32'(f_i_resp), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    f_i_read = 1'b0;
    f_d_read = 1'b0;
  endtask

  initial begin
    //          i d w  i_addr        d_addr        mid_addr      wb     rb     dly hold exp_d rd wr exp_addr
    vecs[0] = '{1, 0, 0, 32'h0000_0040, 32'h0,        32'h0,        8'h00, 8'hA5, 5, 0,   0,    1, 0, 32'h0000_0040};
    vecs[1] = '{0, 0, 1, 32'h0,         32'h0000_1000, 32'h0,       8'h3C, 8'hEE, 3, 0,   1,    0, 1, 32'h0000_1000};
    vecs[2] = '{0, 1, 0, 32'h0,         32'h0000_0100, 32'h0000_0200, 8'h00, 8'h5A, 4, 0, 1,    1, 0, 32'h0000_0100};
    vecs[3] = '{1, 1, 0, 32'h0000_0040, 32'h0000_0080, 32'h0,       8'h00, 8'h11, 2, 1,   1,    1, 0, 32'h0000_0080};
    vecs[4] = '{1, 1, 0, 32'h0000_0040, 32'h0000_0080, 32'h0,       8'h00, 8'h22, 2, 1,   0,    1, 0, 32'h0000_0040};
    vecs[5] = '{1, 1, 0, 32'h0000_0040, 32'h0000_0080, 32'h0,       8'h00, 8'h33, 1, 1,   1,    1, 0, 32'h0000_0080};
    vecs[6] = '{1, 1, 0, 32'h0000_0040, 32'h0000_0080, 32'h0,       8'h00, 8'h44, 2, 0,   0,    1, 0, 32'h0000_0040};

    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    f_i_read = 1'b0; f_d_read = 1'b0; f_d_write = 1'b0;
    f_i_addr = 32'h0000_0040; f_d_addr = 32'h0000_0080; f_d_wdata = '0;
    f_pmem_resp = 1'b0; f_pmem_rdata = '0;
    exp_i = '0;
    exp_d = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cmd", 32'({pmem_read, pmem_write, i_resp, d_resp}), 32'd0);
    check("reset_address", pmem_address, 32'd0);
    check_line("reset_i_rdata", i_rdata, '0);
    check_line("reset_d_rdata", d_rdata, '0);
    check("reset_fixed_cmd", 32'({f_pmem_read, f_pmem_write, f_i_resp, f_d_resp}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      // Reset during a transfer leaves last_owner at I, so the conflict run starts with D.
      if (i == 3) reset_mid_busy();
      do_txn(vecs[i]);
    end

    fixed_priority();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares the single physical-memory cacheline port between the instruction-side cache (fetch) and the data-side cache (the load/store traffic that the execute stage's byte enables ultimately drive).
- Registered-grant FSM: latches one requester's command, drives pmem until pmem_resp, then returns data and a one-cycle resp to that requester.
- Sits between the two L1 caches and the pmem model / L2.

Parameters:
LINE_WIDTH, 256, cacheline width in bits
ADDR_WIDTH, 32, byte address width
ROUND_ROBIN, 1, 1 = alternate on conflict; 0 = fixed D-side priority

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
i_read  input  1  I-side line read request (level, held until i_resp)
i_addr  input  ADDR_WIDTH  I-side line address
i_rdata  output  LINE_WIDTH  I-side returned line
i_resp  output  1  I-side completion pulse
d_read  input  1  D-side line read request (level)
d_write  input  1  D-side line writeback request (level)
d_addr  input  ADDR_WIDTH  D-side line address
d_wdata  input  LINE_WIDTH  D-side writeback data
d_rdata  output  LINE_WIDTH  D-side returned line
d_resp  output  1  D-side completion pulse
pmem_read  output  1  memory read command
pmem_write  output  1  memory write command
pmem_address  output  ADDR_WIDTH  memory line address
pmem_wdata  output  LINE_WIDTH  memory write data
pmem_rdata  input  LINE_WIDTH  memory read data
pmem_resp  input  1  memory completion, one cycle

Behaviour:
- States: IDLE, BUSY, RESP. Owner register: NONE/I/D. last_owner register (RR only).
- Reset (sync): state=IDLE, owner=NONE, last_owner=I; all outputs 0 (rdata regs 0) from the edge where rst is sampled high. Reset mid-BUSY abandons the transfer; a pmem_resp arriving later in IDLE is ignored.
- IDLE: sample requests each posedge. Only I -> owner=I. Only D -> owner=D. Both: ROUND_ROBIN=1 grants the one != last_owner; ROUND_ROBIN=0 grants D. On grant: latch op, address, wdata; go BUSY. No request -> stay IDLE.
- BUSY: pmem_read/pmem_write/pmem_address/pmem_wdata driven purely from latched registers (glitch-free, stable for the whole transfer). Input changes are ignored. On pmem_resp: latch pmem_rdata into the owner's rdata register (reads only); go RESP.
- RESP (exactly 1 cycle): owner's resp=1; pmem commands 0; last_owner<=owner; next state IDLE. Requests are ignored in RESP. A requester drops or changes its request within the resp cycle.
- Latency: request first seen at edge 0 -> pmem command high from edge 0 through the pmem_resp cycle -> resp high in the cycle after pmem_resp. Minimum overhead is 2 cycles over pmem latency. Back-to-back grants have a 1-cycle IDLE gap.
- i_rdata/d_rdata hold their last value until overwritten (not cleared after resp). Writes do not update d_rdata.
- d_read and d_write both high: illegal. Write wins; simulation assertion fires.
- pmem_resp in IDLE or RESP: ignored.
- Non-owner resp is never asserted. At most one of i_resp/d_resp is high in any cycle. pmem_read and pmem_write are never both high.

Decomposition:
- Package arb_types: arb_state_t enum {IDLE, BUSY, RESP}, arb_owner_t enum {OWN_NONE, OWN_I, OWN_D}, LINE_WIDTH default constant.
- One sub-module, arbiter_select: combinational grant from (i_req, d_req, last_owner, ROUND_ROBIN) -> arb_owner_t.
- FSM, latches and output regs stay in cacheline_arbiter.

Test Plan:
- I-only read, addr 0x0000_0040, pmem_resp after 5 cycles with rdata=all-0xA5 -> pmem_read high 5 cycles, i_resp 1 cycle later, i_rdata=0xA5.., d_resp never high.
- D write 0x0000_1000, wdata=all-0x3C -> pmem_write=1, pmem_wdata=0x3C.., pmem_read=0, d_resp 1 cycle after pmem_resp, d_rdata unchanged.
- I read and D read raised the same cycle, ROUND_ROBIN=1, after reset -> D served first, then I (1 IDLE gap). Repeat with both held -> strict alternation D,I,D,I.
- Same conflict, ROUND_ROBIN=0, both held continuously -> D served every time, I starves (check 3 consecutive D grants).
- Change d_addr mid-BUSY 0x100 -> 0x200 -> pmem_address stays 0x100 until resp.
- rst asserted mid-BUSY, stray pmem_resp 2 cycles later -> all outputs 0 after reset edge, no resp pulse, next request served normally.
